irq_ctrl: RTL and testbench

Interrupt controller that sits directly upstream of the RiSC CPU's interrupt logic. It collects device interrupt requests and generates its own periodic timer interrupt. It masks and prioritises the pending requests and presents one request and its line ID to the CPU through a req/ack/done handshake. The CPU programs it through a small control-register window.

---
 rtl/irq_pkg.sv | 23 ++
 rtl/irq_timer.sv | 41 ++++
 rtl/irq_ctrl.sv | 151 +++++++++++++++
 tb/tb_irq_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt controller: control-register
// addresses, FSM state encoding and default sizing.
package irq_pkg;

    localparam int NUM_IRQ_DEFAULT = 8;
    localparam int ID_W_DEFAULT    = 3;
    localparam int TMR_W_DEFAULT   = 16;
    localparam int CR_W            = 16;

    // Control-register window
    localparam logic [1:0] CR_PEND   = 2'd0;
    localparam logic [1:0] CR_MASK   = 2'd1;
    localparam logic [1:0] CR_PERIOD = 2'd2;
    localparam logic [1:0] CR_STATUS = 2'd3;

    // Request handshake state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/irq_timer.sv
// Periodic timer for interrupt line 0. A load writes both the period and the
// running count; with a zero period the counter is frozen. The tick is asserted
// during the cycle in which count==1, so the pending bit is set on the same
// edge that reloads the count: one tick every PERIOD cycles after the load.
module irq_timer
    import irq_pkg::*;
#(
    parameter int TMR_W = TMR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_value,
    output logic [TMR_W-1:0] period,
    output logic             tick
);

    logic [TMR_W-1:0] count;

    assign tick = (period != '0) && (count == TMR_W'(1));

    // Period/count registers: load on write, else count down and reload on tick
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values; blocking here would make ordering between blocks matter.
        if (reset) begin
            period <= '0;
            count  <= '0;
        end else if (load) begin
            period <= load_value;
            count  <= load_value;
        end else if (period != '0) begin
            if (tick) begin
                count <= period;
            end else begin
                count <= count - TMR_W'(1);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller in front of the CPU interrupt logic. Rising edges on
// device lines and timer ticks set pending bits; the lowest-index pending,
// unmasked line is presented to the CPU through a req/ack/done handshake.
// Lines are serviced one at a time with no preemption.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
    parameter int ID_W    = ID_W_DEFAULT,
    parameter int TMR_W   = TMR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-2:0] dev_irq,
    input  logic               int_en,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    input  logic               int_ack,
    input  logic               int_done,
    input  logic               cr_we,
    input  logic [1:0]         cr_addr,
    input  logic [CR_W-1:0]    cr_wdata,
    output logic [CR_W-1:0]    cr_rdata
);

    state_t             state;
    logic               in_service;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-2:0] dev_prev;
    logic [TMR_W-1:0]   period;
    logic               tick;

    logic               wr_pend;
    logic               wr_mask;
    logic               wr_period;
    logic               ack_taken;
    logic [NUM_IRQ-1:0] pend_set;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] active;
    logic               any_active;
    logic [ID_W-1:0]    first_id;
    logic [CR_W-1:0]    status;

    assign wr_pend   = cr_we && (cr_addr == CR_PEND);
    assign wr_mask   = cr_we && (cr_addr == CR_MASK);
    assign wr_period = cr_we && (cr_addr == CR_PERIOD);
    assign ack_taken = (state == REQ) && int_ack;

    irq_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (wr_period),
        .load_value (cr_wdata[TMR_W-1:0]),
        .period     (period),
        .tick       (tick)
    );

    // Sources that set or clear pending bits this cycle; sets win over clears
    assign pend_set = {dev_irq & ~dev_prev, tick};
    assign pend_clr = (wr_pend ? cr_wdata[NUM_IRQ-1:0] : '0)
                    | (ack_taken ? (NUM_IRQ'(1) << int_id) : '0);

    assign active     = pend & mask;
    assign any_active = |active;

    // Priority encoder: lowest-index active line wins
    always_comb begin
        // NOTE: default assignment before the loop keeps this purely combinational;
        // leaving first_id unassigned on some path would infer a latch.
        first_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                first_id = ID_W'(i);
            end
        end
    end

    // Pending, mask and edge-detect history registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pend     <= '0;
            mask     <= '0;
            dev_prev <= '1;
        end else begin
            pend     <= (pend & ~pend_clr) | pend_set;
            dev_prev <= dev_irq;
            if (wr_mask) begin
                mask <= cr_wdata[NUM_IRQ-1:0];
            end
        end
    end

    // Request handshake FSM with registered int_req/int_id/in_service
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            int_id     <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (int_en && any_active) begin
                        int_id  <= first_id;
                        int_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                        state      <= SERVICE;
                    end else if (!int_en || !mask[int_id]) begin
                        int_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                SERVICE: begin
                    if (int_done) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    int_req    <= 1'b0;
                    in_service <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign status = CR_W'(int_id) | {in_service, int_req, {(CR_W - 2){1'b0}}};

    // Control-register read mux
    always_comb begin
        cr_rdata = '0;
        case (cr_addr)
            CR_PEND:   cr_rdata = CR_W'(pend);
            CR_MASK:   cr_rdata = CR_W'(mask);
            CR_PERIOD: cr_rdata = CR_W'(period);
            CR_STATUS: cr_rdata = status;
            default:   cr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl: reset state, edge-triggered requests,
// periodic timer, priority, global enable, set-over-clear and mid-service reset.
module tb_irq_ctrl;
    import irq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  dev_irq;
    logic        int_en;
    logic        int_req;
    logic [2:0]  int_id;
    logic        int_ack;
    logic        int_done;
    logic        cr_we;
    logic [1:0]  cr_addr;
    logic [15:0] cr_wdata;
    logic [15:0] cr_rdata;

    int tests = 0;
    int fails = 0;

    irq_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .dev_irq  (dev_irq),
        .int_en   (int_en),
        .int_req  (int_req),
        .int_id   (int_id),
        .int_ack  (int_ack),
        .int_done (int_done),
        .cr_we    (cr_we),
        .cr_addr  (cr_addr),
        .cr_wdata (cr_wdata),
        .cr_rdata (cr_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1ns past the edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [15:0] data);
        cr_we    = 1'b1;
        cr_addr  = addr;
        cr_wdata = data;
        step(1);
        cr_we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [15:0] exp);
        cr_addr = addr;
        #1;
        check(tag, cr_rdata, exp);
    endtask

    task automatic ack_pulse();
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
    endtask

    task automatic done_pulse();
        int_done = 1'b1;
        step(1);
        int_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        dev_irq  = '0;
        int_en   = 1'b0;
        int_ack  = 1'b0;
        int_done = 1'b0;
        cr_we    = 1'b0;
        cr_addr  = CR_PEND;
        cr_wdata = '0;
        step(2);
        reset = 1'b0;

        // Reset state
        check("rst_req", 16'(int_req), 16'h0);
        check("rst_id", 16'(int_id), 16'h0);
        rd_chk("rst_pend", CR_PEND, 16'h0000);
        rd_chk("rst_mask", CR_MASK, 16'h0000);
        rd_chk("rst_period", CR_PERIOD, 16'h0000);
        rd_chk("rst_status", CR_STATUS, 16'h0000);

        // 1: single device line, full handshake
        wr(CR_MASK, 16'h0002);
        rd_chk("t1_mask", CR_MASK, 16'h0002);
        int_en  = 1'b1;
        dev_irq = 7'b0000001;
        step(1);
        rd_chk("t1_pend_set", CR_PEND, 16'h0002);
        check("t1_req_lat", 16'(int_req), 16'h0);
        step(1);
        check("t1_req", 16'(int_req), 16'h1);
        check("t1_id", 16'(int_id), 16'h1);
        ack_pulse();
        rd_chk("t1_pend_ack", CR_PEND, 16'h0000);
        rd_chk("t1_status_svc", CR_STATUS, 16'h8001);
        done_pulse();
        rd_chk("t1_status_idle", CR_STATUS, 16'h0001);
        dev_irq = '0;

        // 2: periodic timer, PERIOD=5
        wr(CR_MASK, 16'h0001);
        wr(CR_PERIOD, 16'd5);
        rd_chk("t2_period", CR_PERIOD, 16'd5);
        step(4);
        rd_chk("t2_pend_early", CR_PEND, 16'h0000);
        step(1);
        rd_chk("t2_tick1", CR_PEND, 16'h0001);
        step(1);
        check("t2_req1", 16'(int_req), 16'h1);
        check("t2_id1", 16'(int_id), 16'h0);
        ack_pulse();
        done_pulse();
        step(1);
        rd_chk("t2_pend_gap", CR_PEND, 16'h0000);
        step(1);
        rd_chk("t2_tick2", CR_PEND, 16'h0001);
        step(1);
        check("t2_req2", 16'(int_req), 16'h1);
        check("t2_id2", 16'(int_id), 16'h0);
        ack_pulse();
        done_pulse();
        wr(CR_PERIOD, 16'd0);
        rd_chk("t2_period_off", CR_PERIOD, 16'd0);
        step(6);
        rd_chk("t2_no_tick", CR_PEND, 16'h0000);

        // 3: lines 3 and 5 together, lowest index first
        wr(CR_MASK, 16'h00FF);
        dev_irq = 7'b0010100;
        step(1);
        rd_chk("t3_pend", CR_PEND, 16'h0028);
        step(1);
        check("t3_id_first", 16'(int_id), 16'h3);
        ack_pulse();
        rd_chk("t3_pend_mid", CR_PEND, 16'h0020);
        done_pulse();
        step(1);
        check("t3_req_second", 16'(int_req), 16'h1);
        check("t3_id_second", 16'(int_id), 16'h5);
        ack_pulse();
        done_pulse();
        rd_chk("t3_pend_end", CR_PEND, 16'h0000);
        dev_irq = '0;

        // 4: global enable gating and enable drop in REQ
        int_en = 1'b0;
        wr(CR_MASK, 16'h0004);
        dev_irq = 7'b0000010;
        step(1);
        step(2);
        check("t4_req_gated", 16'(int_req), 16'h0);
        rd_chk("t4_pend", CR_PEND, 16'h0004);
        int_en = 1'b1;
        step(1);
        check("t4_req_en", 16'(int_req), 16'h1);
        check("t4_id", 16'(int_id), 16'h2);
        int_en = 1'b0;
        step(1);
        check("t4_req_drop", 16'(int_req), 16'h0);
        rd_chk("t4_pend_kept", CR_PEND, 16'h0004);
        wr(CR_PEND, 16'h0004);
        rd_chk("t4_w1c", CR_PEND, 16'h0000);
        dev_irq = '0;

        // 5: set wins over W1C and over ack-clear
        wr(CR_MASK, 16'h0002);
        cr_we    = 1'b1;
        cr_addr  = CR_PEND;
        cr_wdata = 16'h0002;
        dev_irq  = 7'b0000001;
        step(1);
        cr_we    = 1'b0;
        rd_chk("t5_w1c_vs_set", CR_PEND, 16'h0002);
        dev_irq = '0;
        step(1);
        int_en = 1'b1;
        step(1);
        check("t5_req", 16'(int_req), 16'h1);
        check("t5_id", 16'(int_id), 16'h1);
        int_ack = 1'b1;
        dev_irq = 7'b0000001;
        step(1);
        int_ack = 1'b0;
        rd_chk("t5_status_svc", CR_STATUS, 16'h8001);
        rd_chk("t5_ack_vs_set", CR_PEND, 16'h0002);
        done_pulse();
        step(1);
        check("t5_rereq", 16'(int_req), 16'h1);
        check("t5_reid", 16'(int_id), 16'h1);
        ack_pulse();
        done_pulse();
        rd_chk("t5_pend_end", CR_PEND, 16'h0000);
        dev_irq = '0;

        // 6: reset while in SERVICE with timer running
        wr(CR_MASK, 16'h0002);
        wr(CR_PERIOD, 16'd3);
        dev_irq = 7'b0000001;
        step(2);
        ack_pulse();
        rd_chk("t6_status_svc", CR_STATUS, 16'h8001);
        reset   = 1'b1;
        dev_irq = 7'b1000001;
        step(1);
        check("t6_req_rst", 16'(int_req), 16'h0);
        rd_chk("t6_status_rst", CR_STATUS, 16'h0000);
        rd_chk("t6_period_rst", CR_PERIOD, 16'h0000);
        rd_chk("t6_pend_rst", CR_PEND, 16'h0000);
        rd_chk("t6_mask_rst", CR_MASK, 16'h0000);
        reset = 1'b0;
        step(8);
        rd_chk("t6_pend_after", CR_PEND, 16'h0000);
        check("t6_req_after", 16'(int_req), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
